// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface mips_fetch_if;
    import mips_fetch_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [31:0]        if_pc;
    logic               if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
    );

endinterface

// File: rtl/mips_fetch_skid_buffer.sv
// Two-entry in-order queue of fetched words; the head register holds its last
// value once drained so the decode-side outputs stay stable while empty.
module fetch_skid_buffer
    import mips_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Shift only when a second entry exists; otherwise keep head.
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: PC register, single-outstanding memory request FSM and
// redirect handling in front of a 2-entry skid buffer.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_fetch_if.master  bus
);

    localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

    fetch_state_t state;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic [1:0]   occ;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         ack, pop, push, redirect;
    logic [31:0]  pc_inc, rpc;

    assign redirect   = bus.redirect_valid;
    assign ack        = bus.imem_ack & bus.imem_req;
    assign pop        = (count != 2'd0) & bus.if_ready & ~redirect;
    assign occ        = count - {1'b0, pop};
    assign push       = (state == WAIT) & ack & ~redirect;
    assign pc_inc     = pc + PC_STEP;
    assign rpc        = align_pc(bus.redirect_pc);
    assign push_entry = '{pc: pc, instr: bus.imem_rdata};

    fetch_skid_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .count (count),
        .head  (head)
    );

    assign bus.if_valid = (count != 2'd0);
    assign bus.if_instr = head.instr;
    assign bus.if_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= PC0;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= PC0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= rpc;
                    end else if (occ < 2'd2) begin
                        bus.imem_req  <= 1'b1;
                        bus.imem_addr <= pc;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack && redirect) begin
                        // Returned word is stale; restart straight at the target.
                        pc            <= rpc;
                        bus.imem_addr <= rpc;
                    end else if (ack) begin
                        pc <= pc_inc;
                        if (occ == 2'd0) begin
                            bus.imem_addr <= pc_inc;
                        end else begin
                            bus.imem_req <= 1'b0;
                            state        <= IDLE;
                        end
                    end else if (redirect) begin
                        pc    <= rpc;
                        state <= DROP;
                    end
                end
                DROP: begin
                    // Buffer was flushed on entry and nothing pushes here,
                    // so there is always room to reissue right away.
                    if (ack) begin
                        pc            <= redirect ? rpc : pc;
                        bus.imem_addr <= redirect ? rpc : pc;
                        state         <= WAIT;
                    end else if (redirect) begin
                        pc <= rpc;
                    end
                end
                default: begin
                    bus.imem_req <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with a configurable-latency memory model.
module tb_mips_fetch_unit;
    import mips_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ack_force;
    int          lat;
    int          wcnt;
    int          acks;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        mem_ack;

    mips_fetch_if bus ();
    mips_fetch_if bus2 ();

    mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h00E9_1020;
            32'h0000_0004: return 32'h004A_1822;
            default:       return addr ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory acks 'lat' cycles after the request rises; ack_force injects a stray ack.
    assign mem_ack             = ack_force | (bus.imem_req && (wcnt == lat));
    assign bus.imem_ack        = mem_ack;
    assign bus.imem_rdata      = instr_of(bus.imem_addr);
    assign bus.redirect_valid  = redirect_valid;
    assign bus.redirect_pc     = redirect_pc;
    assign bus.if_ready        = if_ready;

    assign bus2.imem_ack       = bus2.imem_req;
    assign bus2.imem_rdata     = instr_of(bus2.imem_addr);
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;
    assign bus2.if_ready       = 1'b1;

    always @(posedge clk) begin
        if (!rst_n || !bus.imem_req || mem_ack) wcnt <= 0;
        else                                     wcnt <= wcnt + 1;
        if (!rst_n)                              acks <= 0;
        else if (mem_ack && bus.imem_req)        acks <= acks + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ack_force      = 1'b0;
        lat            = 0;

        // Reset values, then zero-latency stream (both instances).
        tick();
        tick();
        chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("rst_instr", bus.if_instr, 32'h0);
        chk("rst_pc",    bus.if_pc, 32'h0);
        chk("rst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        tick();
        chk("s1_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("s1_addr",  bus.imem_addr, 32'h0);
        chk("s1_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("w1_addr",  bus2.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("s2_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("s2_pc",    bus.if_pc, 32'h0);
        chk("s2_instr", bus.if_instr, 32'h00E9_1020);
        chk("s2_addr",  bus.imem_addr, 32'h4);
        chk("w2_pc",    bus2.if_pc, 32'hFFFF_FFFC);
        chk("w2_instr", bus2.if_instr, 32'hA5A5_FFFC);
        chk("w2_addr",  bus2.imem_addr, 32'h0);
        tick();
        chk("s3_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("s3_pc",    bus.if_pc, 32'h4);
        chk("s3_instr", bus.if_instr, 32'h004A_1822);
        chk("w3_pc",    bus2.if_pc, 32'h0);
        chk("w3_instr", bus2.if_instr, 32'h00E9_1020);

        // Backpressure: two words accepted then the request drops.
        if_ready = 1'b0;
        do_reset();
        tick();
        tick();
        chk("bp2_addr", bus.imem_addr, 32'h4);
        tick();
        chk("bp3_req",  {31'b0, bus.imem_req}, 32'd0);
        tick();
        tick();
        tick();
        chk("bp6_acks",  acks, 32'd2);
        chk("bp6_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("bp6_pc",    bus.if_pc, 32'h0);
        chk("bp6_instr", bus.if_instr, 32'h00E9_1020);
        if_ready = 1'b1;
        tick();
        chk("bp7_pc",   bus.if_pc, 32'h4);
        chk("bp7_req",  {31'b0, bus.imem_req}, 32'd1);
        chk("bp7_addr", bus.imem_addr, 32'h8);
        tick();
        chk("bp8_pc",    bus.if_pc, 32'h8);
        chk("bp8_instr", bus.if_instr, 32'h5A5A_0008);
        chk("bp8_addr",  bus.imem_addr, 32'hC);

        // Redirect while waiting on a slow memory: old address held, stale word dropped.
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("rd3_addr",  bus.imem_addr, 32'h0);
        chk("rd3_valid", {31'b0, bus.if_valid}, 32'd0);
        tick();
        chk("rd4_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("rd4_addr",  bus.imem_addr, 32'h0);
        tick();
        chk("rd5_addr",  bus.imem_addr, 32'h100);
        chk("rd5_valid", {31'b0, bus.if_valid}, 32'd0);
        tick();
        tick();
        tick();
        chk("rd8_valid", {31'b0, bus.if_valid}, 32'd0);
        tick();
        chk("rd9_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("rd9_pc",    bus.if_pc, 32'h100);
        chk("rd9_instr", bus.if_instr, 32'h5A5A_0100);

        // Redirect in the same cycle as the ack for address 8.
        lat = 0;
        do_reset();
        tick();
        tick();
        tick();
        chk("ra3_addr", bus.imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("ra4_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("ra4_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("ra4_addr",  bus.imem_addr, 32'h200);
        tick();
        chk("ra5_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("ra5_pc",    bus.if_pc, 32'h200);
        chk("ra5_instr", bus.if_instr, 32'h5A5A_0200);

        // Reset with a request outstanding and a buffered word; stray ack ignored.
        lat      = 2;
        if_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        chk("mr4_valid", {31'b0, bus.if_valid}, 32'd1);
        chk("mr4_addr",  bus.imem_addr, 32'h4);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mr6_req",   {31'b0, bus.imem_req}, 32'd0);
        chk("mr6_addr",  bus.imem_addr, 32'h0);
        chk("mr6_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("mr6_instr", bus.if_instr, 32'h0);
        chk("mr6_pc",    bus.if_pc, 32'h0);
        rst_n     = 1'b1;
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("mr7_valid", {31'b0, bus.if_valid}, 32'd0);
        chk("mr7_req",   {31'b0, bus.imem_req}, 32'd1);
        chk("mr7_addr",  bus.imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
